// File: rtl/mem_access_stage_pkg.sv
// Opcode constants, op-kind encoding and FSM states
// shared by the memory-access stage and its load aligner.
package mem_access_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef struct packed {
        logic  store;
        logic  unsgn;
        size_e size;
    } op_kind_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    function automatic logic is_memop(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: is_memop = 1'b1;
            default:             is_memop = 1'b0;
        endcase
    endfunction

    // Only valid for memory opcodes: bit 3 = store,
    // bit 2 = unsigned load, bits 1:0 = access size.
    function automatic op_kind_t decode_op(input logic [5:0] op);
        op_kind_t k;
        k.store = op[3];
        k.unsgn = op[2];
        case (op[1:0])
            2'b00:   k.size = SZ_B;
            2'b01:   k.size = SZ_H;
            default: k.size = SZ_W;
        endcase
        return k;
    endfunction

    function automatic logic is_aligned(input size_e sz,
                                        input logic [1:0] off);
        case (sz)
            SZ_B:    is_aligned = 1'b1;
            SZ_H:    is_aligned = ~off[0];
            default: is_aligned = (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input size_e sz,
                                           input logic [1:0] off);
        case (sz)
            SZ_B:    byte_en = 4'b0001 << off;
            SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input size_e sz,
                                               input logic [31:0] w);
        case (sz)
            SZ_B:    store_data = {4{w[7:0]}};
            SZ_H:    store_data = {2{w[15:0]}};
            default: store_data = w;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Lane selection and sign/zero extension of captured read data.
module load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [3:0]  kind_i,
    output logic [31:0] data_o
);

    op_kind_t    kind;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        unused_store;

    assign kind         = op_kind_t'(kind_i);
    assign unused_store = kind.store;

    always_comb begin
        byte_sel = rdata_i[7:0];
        unique case (off_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
        endcase
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (kind.size)
            SZ_B: data_o = kind.unsgn ? {24'h0, byte_sel}
                                      : {{24{byte_sel[7]}}, byte_sel};
            SZ_H: data_o = kind.unsgn ? {16'h0, half_sel}
                                      : {{16{half_sel[15]}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: byte/half/word loads and stores over a
// req/ack bus, stalling upstream while a transfer is outstanding.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Valid,
    input  logic [31:0] Ins,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic        Stall,
    output logic [31:0] LoadData,
    output logic        Done,
    output logic        AddrErr,
    output logic        BusErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    op_kind_t         kind_q;
    logic [1:0]       off_q;
    logic [31:0]      rdata_q;
    logic             req_q;
    logic             we_q;
    logic [29:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             done_q;
    logic             aerr_q;
    logic             berr_q;

    logic [5:0]       opcode;
    logic             memop_d;
    op_kind_t         kind_d;
    logic             aligned_d;
    logic [3:0]       be_d;
    logic [31:0]      wdata_d;
    logic [31:0]      align_data;
    logic             unused_ins;

    assign opcode     = Ins[31:26];
    assign unused_ins = ^Ins[25:0];
    assign memop_d    = is_memop(opcode);
    assign kind_d     = decode_op(opcode);
    assign aligned_d  = is_aligned(kind_d.size, Addr[1:0]);
    assign be_d       = byte_en(kind_d.size, Addr[1:0]);
    assign wdata_d    = kind_d.store ? store_data(kind_d.size, Wdata)
                                     : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            kind_q  <= '0;
            off_q   <= 2'b00;
            rdata_q <= 32'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 30'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            aerr_q <= 1'b0;
            berr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Valid && memop_d) begin
                        if (!aligned_d) begin
                            aerr_q  <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= kind_d.store;
                            addr_q  <= Addr[31:2];
                            be_q    <= be_d;
                            wdata_q <= wdata_d;
                            kind_q  <= kind_d;
                            off_q   <= Addr[1:0];
                            cnt_q   <= '0;
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        req_q   <= 1'b0;
                        berr_q  <= 1'b1;
                        state_q <= S_ERR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    load_align u_align (
        .rdata_i (rdata_q),
        .off_i   (off_q),
        .kind_i  (kind_q),
        .data_o  (align_data)
    );

    assign Stall = (state_q == S_BUSY) ||
                   (state_q == S_IDLE && Valid && memop_d && aligned_d);

    assign LoadData  = done_q ? align_data : 32'h0;
    assign Done      = done_q;
    assign AddrErr   = aerr_q;
    assign BusErr    = berr_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table, random loads/stores
// against a byte-level memory model, timeout and reset sequences.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Valid;
    logic [31:0] Ins, Addr, Wdata;
    logic        Stall, Done, AddrErr, BusErr;
    logic [31:0] LoadData;
    logic        mem_req, mem_we, mem_ack;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    mem_access_stage #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .Valid(Valid), .Ins(Ins),
        .Addr(Addr), .Wdata(Wdata), .Stall(Stall),
        .LoadData(LoadData), .Done(Done), .AddrErr(AddrErr),
        .BusErr(BusErr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          aerr_n, berr_n, done_cyc, stall_n;
        bit          req_seen, unstable, hang;
        logic [29:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata, load;
    } obs_t;

    typedef struct {
        bit          aerr, berr, req, we, is_load;
        logic [3:0]  be;
        logic [29:0] addr;
        logic [31:0] wdata, load;
        int          done_cyc, stall_n;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr, wd, rd;
        int          waits;
        exp_t        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Present one instruction and act as the bus slave; ack after
    // `waits` wait cycles. Starts and ends at a negedge in IDLE.
    task automatic do_txn(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, output obs_t o);
        int  busy_n;
        bit  fin;
        busy_n = 0;
        fin = 0;
        o.aerr_n = 0; o.berr_n = 0; o.done_cyc = -1; o.stall_n = 0;
        o.req_seen = 0; o.unstable = 0; o.hang = 0;
        o.addr = '0; o.be = '0; o.we = 0; o.wdata = '0; o.load = '0;
        Ins = {op, 26'h0};
        Addr = a;
        Wdata = wd;
        Valid = 1'b1;
        mem_ack = 1'b0;
        for (int c = 0; c < 64; c++) begin
            #1;
            if (Stall) o.stall_n++;
            if (mem_req) begin
                if (!o.req_seen) begin
                    o.addr = mem_addr; o.be = mem_be;
                    o.we = mem_we; o.wdata = mem_wdata;
                end else if (o.addr !== mem_addr || o.be !== mem_be ||
                             o.we !== mem_we || o.wdata !== mem_wdata) begin
                    o.unstable = 1;
                end
                o.req_seen = 1;
                mem_ack = (busy_n == waits);
                mem_rdata = mem_ack ? rd : 32'hx;
                busy_n++;
            end else begin
                mem_ack = 1'b0;
            end
            if (Done) begin
                o.done_cyc = c;
                o.load = LoadData;
            end
            if (AddrErr) o.aerr_n++;
            if (BusErr) o.berr_n++;
            if (Done || AddrErr || BusErr) begin
                fin = 1;
                break;
            end
            @(posedge CLK);
            @(negedge CLK);
        end
        if (!fin) o.hang = 1;
        Valid = 1'b0;
        mem_ack = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        n_vec++;
    endtask

    task automatic check_txn(input string nm, input exp_t e,
                             input obs_t o);
        chk({nm, ".hang"}, 32'(o.hang), 32'(1'b0));
        chk({nm, ".aerr"}, 32'(o.aerr_n), 32'(e.aerr));
        chk({nm, ".berr"}, 32'(o.berr_n), 32'(e.berr));
        chk({nm, ".done_cyc"}, 32'(o.done_cyc), 32'(e.done_cyc));
        chk({nm, ".stall_n"}, 32'(o.stall_n), 32'(e.stall_n));
        chk({nm, ".req"}, 32'(o.req_seen), 32'(e.req));
        if (e.req) begin
            chk({nm, ".addr"}, 32'(o.addr), 32'(e.addr));
            chk({nm, ".be"}, 32'(o.be), 32'(e.be));
            chk({nm, ".we"}, 32'(o.we), 32'(e.we));
            chk({nm, ".stable"}, 32'(o.unstable), 32'(1'b0));
            if (e.we) chk({nm, ".wdata"}, o.wdata, e.wdata);
        end
        if (e.is_load) chk({nm, ".load"}, o.load, e.load);
    endtask

    function automatic vec_t mk(input logic [5:0] op,
                                input logic [31:0] a, wd, rd,
                                input int waits, input bit aerr,
                                input logic [3:0] be, input bit we,
                                input logic [31:0] wdata, load,
                                input int done);
        vec_t v;
        v.op = op; v.addr = a; v.wd = wd; v.rd = rd; v.waits = waits;
        v.e.aerr = aerr; v.e.berr = 0; v.e.req = !aerr;
        v.e.we = we; v.e.is_load = !we && !aerr;
        v.e.be = be; v.e.addr = a[31:2];
        v.e.wdata = wdata; v.e.load = load;
        v.e.done_cyc = done;
        v.e.stall_n = (done < 0) ? 0 : done;
        return v;
    endfunction

    // Reference: byte-oriented view of each access.
    function automatic exp_t model(input logic [5:0] op,
                                   input logic [31:0] a, wd, rd,
                                   input int waits);
        exp_t   e;
        int     sz, off;
        bit     sgn, st;
        longint mask, v;
        sz = 4; sgn = 0; st = 0;
        case (op)
            6'h20: begin sz = 1; sgn = 1; end
            6'h21: begin sz = 2; sgn = 1; end
            6'h24: sz = 1;
            6'h25: sz = 2;
            6'h28: begin sz = 1; st = 1; end
            6'h29: begin sz = 2; st = 1; end
            6'h2B: st = 1;
            default: sz = 4;
        endcase
        off = int'(a % 4);
        e.aerr = (a % sz) != 0;
        e.berr = 0;
        e.req = !e.aerr;
        e.we = st;
        e.is_load = !st && !e.aerr;
        e.be = 4'(((1 << sz) - 1) << off);
        e.addr = 30'(a / 4);
        if (sz == 1) e.wdata = (wd % 256) * 32'h01010101;
        else if (sz == 2) e.wdata = (wd % 65536) * 32'h00010001;
        else e.wdata = wd;
        mask = (64'd1 << (8 * sz)) - 1;
        v = (longint'(rd) >> (8 * off)) & mask;
        if (sgn && v > mask / 2) v = v - (mask + 1);
        e.load = 32'(v);
        e.done_cyc = e.aerr ? -1 : 2 + waits;
        e.stall_n = e.aerr ? 0 : 2 + waits;
        return e;
    endfunction

    vec_t        tbl[$];
    obs_t        o;
    exp_t        e;
    logic [31:0] mem_m [16];
    logic [5:0]  memops [8];
    logic [5:0]  nonmem [5];

    initial begin
        RST = 1'b1; Valid = 1'b0; Ins = '0; Addr = '0; Wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        memops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        nonmem = '{6'h00, 6'h08, 6'h22, 6'h2A, 6'h0F};
        for (int i = 0; i < 16; i++) mem_m[i] = $urandom();

        tbl.push_back(mk(6'h23, 32'h104, 0, 32'hDEADBEEF, 0, 0,
                         4'hF, 0, 0, 32'hDEADBEEF, 2));
        tbl.push_back(mk(6'h20, 32'h203, 0, 32'h80112233, 0, 0,
                         4'h8, 0, 0, 32'hFFFFFF80, 2));
        tbl.push_back(mk(6'h24, 32'h203, 0, 32'h80112233, 0, 0,
                         4'h8, 0, 0, 32'h00000080, 2));
        tbl.push_back(mk(6'h21, 32'h202, 0, 32'h80112233, 0, 0,
                         4'hC, 0, 0, 32'hFFFF8011, 2));
        tbl.push_back(mk(6'h25, 32'h200, 0, 32'h80112233, 0, 0,
                         4'h3, 0, 0, 32'h00002233, 2));
        tbl.push_back(mk(6'h29, 32'h12, 32'h0000ABCD, 0, 3, 0,
                         4'hC, 1, 32'hABCDABCD, 0, 5));
        tbl.push_back(mk(6'h28, 32'h1, 32'h0000005A, 0, 1, 0,
                         4'h2, 1, 32'h5A5A5A5A, 0, 3));
        tbl.push_back(mk(6'h2B, 32'h40, 32'h12345678, 0, 0, 0,
                         4'hF, 1, 32'h12345678, 0, 2));
        tbl.push_back(mk(6'h23, 32'h102, 0, 0, 0, 1, 0, 0, 0, 0, -1));
        tbl.push_back(mk(6'h29, 32'h13, 0, 0, 0, 1, 0, 1, 0, 0, -1));
        tbl.push_back(mk(6'h20, 32'h2, 0, 32'h12FE3456, 0, 0,
                         4'h4, 0, 0, 32'hFFFFFFFE, 2));
        tbl.push_back(mk(6'h25, 32'h2, 0, 32'hBEEF1234, 2, 0,
                         4'hC, 0, 0, 32'h0000BEEF, 4));

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst.stall", 32'(Stall), 0);
        chk("rst.req", 32'(mem_req), 0);
        chk("rst.we", 32'(mem_we), 0);
        chk("rst.be", 32'(mem_be), 0);
        chk("rst.done", 32'(Done), 0);
        chk("rst.aerr", 32'(AddrErr), 0);
        chk("rst.berr", 32'(BusErr), 0);
        chk("rst.load", LoadData, 0);
        @(negedge CLK);

        foreach (tbl[i]) begin
            do_txn(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].rd,
                   tbl[i].waits, o);
            check_txn($sformatf("tbl%0d", i), tbl[i].e, o);
        end

        // No ack: bus error after TMO busy cycles, late ack ignored
        e = model(6'h2B, 32'h80, 32'h11223344, 0, 0);
        e.berr = 1;
        e.done_cyc = -1;
        e.stall_n = 1 + TMO;
        do_txn(6'h2B, 32'h80, 32'h11223344, 0, 1000, o);
        check_txn("timeout", e, o);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge CLK);
        @(negedge CLK);
        chk("late_ack.done", 32'(Done), 0);
        chk("late_ack.req", 32'(mem_req), 0);
        chk("late_ack.berr", 32'(BusErr), 0);
        mem_ack = 1'b0;

        // Reset while BUSY abandons the transfer
        Ins = {6'h23, 26'h0}; Addr = 32'h100; Valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rstbusy.req_before", 32'(mem_req), 1);
        RST = 1'b1;
        Valid = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        chk("rstbusy.req", 32'(mem_req), 0);
        chk("rstbusy.stall", 32'(Stall), 0);
        chk("rstbusy.be", 32'(mem_be), 0);
        chk("rstbusy.done", 32'(Done), 0);
        chk("rstbusy.load", LoadData, 0);
        RST = 1'b0;
        mem_ack = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("rstbusy.late_done", 32'(Done), 0);
        mem_ack = 1'b0;
        Ins = {6'h00, 20'h0, 6'h20};
        Valid = 1'b1;
        #1;
        chk("add.stall", 32'(Stall), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("add.req", 32'(mem_req), 0);
        chk("add.done", 32'(Done), 0);
        Valid = 1'b0;
        n_vec++;

        for (int i = 0; i < 80; i++) begin
            logic [5:0]  op;
            logic [31:0] a, wd, rd;
            int          w, wi, sz;
            if ($urandom_range(0, 7) == 0) begin
                op = nonmem[$urandom_range(0, 4)];
                Ins = {op, 26'(($urandom()))};
                Addr = $urandom(); Wdata = $urandom(); Valid = 1'b1;
                #1;
                chk($sformatf("rnd%0d.nm_stall", i), 32'(Stall), 0);
                @(posedge CLK);
                @(negedge CLK);
                chk($sformatf("rnd%0d.nm_req", i), 32'(mem_req), 0);
                chk($sformatf("rnd%0d.nm_load", i), LoadData, 0);
                chk($sformatf("rnd%0d.nm_aerr", i), 32'(AddrErr), 0);
                Valid = 1'b0;
                n_vec++;
                continue;
            end
            op = memops[$urandom_range(0, 7)];
            wi = $urandom_range(0, 15);
            a = 32'h1000 + 32'(wi * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                sz = (op == 6'h20 || op == 6'h24 || op == 6'h28) ? 1 :
                     (op == 6'h21 || op == 6'h25 || op == 6'h29) ? 2 : 4;
                a = a - (a % sz);
            end
            wd = $urandom();
            rd = mem_m[wi];
            w = $urandom_range(0, 3);
            e = model(op, a, wd, rd, w);
            do_txn(op, a, wd, rd, w, o);
            check_txn($sformatf("rnd%0d", i), e, o);
            if (e.we && !e.aerr) begin
                for (int b = 0; b < 4; b++)
                    if (e.be[b]) mem_m[wi][8*b +: 8] = e.wdata[8*b +: 8];
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
